divrem_signed_ctrl: RTL
=======================

Name: divrem_signed_ctrl

Overview:
- Front end for the unsigned multi-cycle divider (divu_remu).
- Executes RISC-V M-extension DIV/DIVU/REM/REMU for the execute stage: latches operands, converts them to magnitudes, issues to the unsigned core, and sign-corrects its result.
- Handles RISC-V divide-by-zero and signed-overflow results.
- Owns the order/accepted/done handshake toward the pipeline; holds core inputs stable for the whole core operation.

Parameters:
- LEN, 32, operand/result width; must equal `LEN_WORD.
- CORE_TIMEOUT, 15, maximum WAIT cycles before the sticky error flag is set (verification aid only; no functional effect).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- order  in  1  request from execute stage
- accepted  out  1  request taken this cycle (combinational)
- done  out  1  one-cycle pulse; rd valid
- rs1  in  LEN  dividend; sampled only when accepted=1
- rs2  in  LEN  divisor; sampled only when accepted=1
- funct  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with operands
- rd  out  LEN  registered result
- timeout_err  out  1  sticky; set if WAIT exceeds CORE_TIMEOUT
- core_order  out  1  to divu_remu.order
- core_accepted  in  1  from divu_remu.accepted
- core_done  in  1  from divu_remu.done
- core_rs1  out  LEN  |dividend|, registered
- core_rs2  out  LEN  |divisor|, registered
- core_rem_flag  out  1  1 for REM/REMU, registered
- core_rd  in  LEN  unsigned result; valid while core_done=1

Behaviour:
- Reset, asynchronous active-low, effective immediately at any point including mid-operation:
  - state=IDLE.
  - rd, core_rs1, core_rs2 = 0.
  - core_rem_flag, done, core_order, timeout_err = 0.
  - Any in-flight result is discarded. The core shares rstn, so both sides restart together.
- IDLE:
  - accepted = order & (state==IDLE).
  - On accept, latch the following, then go to ISSUE:
    - sign flag = (funct[0]==0).
    - neg_q = signed & (rs1[LEN-1] ^ rs2[LEN-1]).
    - neg_r = signed & rs1[LEN-1].
    - zero_div = (rs2==0).
    - orig_rs1 = rs1.
    - core_rs1 = signed&rs1[LEN-1] ? -rs1 : rs1; core_rs2 likewise for rs2 (two's-complement negate, LEN bits).
    - core_rem_flag = funct[1].
- ISSUE:
  - core_order=1.
  - When core_accepted=1, go to WAIT in the same cycle.
  - core_order is held while core_accepted=0.
- WAIT:
  - core_order=0; cycle counter increments.
  - On core_done:
    - R = core_rd.
    - Quotient path: rd = zero_div ? all-ones : (neg_q ? -R : R).
    - Remainder path: rd = neg_r ? -R : R.
    - Go to DONE.
  - If counter > CORE_TIMEOUT, set timeout_err. The FSM keeps waiting.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - rd holds its value until the next DONE.
  - No accept in DONE; the earliest next accept is the cycle after done.
- Latency: accept at cycle T → ISSUE T+1 (core accepts) → core_done T+5 (4-stage core) → done at T+6.
- Special cases, all without extra hardware in the core:
  - Divide by zero:
    - Core returns Q=all-ones, R=|rs1|.
    - Quotient forced to all-ones (no sign fix).
    - Remainder sign fix yields orig rs1.
  - Overflow, DIV 0x80000000 / 0xFFFFFFFF:
    - |rs1| = 0x80000000, neg_q=0.
    - Q=0x80000000, R=0. Naturally correct.
  - Unsigned ops: no negation, neg_q = neg_r = 0.
- Inputs rs1/rs2/funct may change freely after accept.
- order is ignored outside IDLE.

Optional Feature:
- Macro: DIVREM_FAST_SPECIAL_EN.
- Defined:
  - In IDLE, if zero_div, or signed & rs1==0x80000000 & rs2==all-ones, skip ISSUE/WAIT.
  - rd is loaded with the RISC-V result in the accept cycle; DONE follows at T+1.
  - The core is not ordered.
- Undefined: every op goes through the core, with the 6-cycle latency above.

Decomposition:
- Shared package divrem_pkg:
  - funct codes FN_DIV/FN_DIVU/FN_REM/FN_REMU.
  - FSM state encoding IDLE/ISSUE/WAIT/DONE.
  - CORE_STAGES=4.
- Sub-module divrem_sign_adj: combinational conditional two's-complement negate (in, neg → out). Instantiated for:
  - rs1 and rs2 on the input side.
  - the result on the output side.

Test Plan:
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 → done at T+6, rd=0xFFFFFFFD (-3); REM same operands → rd=0xFFFFFFFF (-1).
- DIVU 0xFFFFFFFF/0x10 → rd=0x0FFFFFFF; REMU → rd=0xF; core_rs1/core_rs2 equal raw operands.
- DIV -5/0 → rd=0xFFFFFFFF; REM -5/0 → rd=0xFFFFFFFB; DIVU 9/0 → 0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF → rd=0x80000000; REM → 0; with DIVREM_FAST_SPECIAL_EN, done at T+1 and core_order never rises.
- Back-to-back: order held high for two ops; second accepted the cycle after first done; order pulses during ISSUE/WAIT are ignored (accepted=0).
- Reset asserted during WAIT → all outputs 0 immediately, state IDLE; the next op after reset release completes with the correct result and no stale done.

Source files
------------

// File: rtl/divrem_pkg.sv
// +-----------------------------------------------------------------------------+
// | Module   : divrem_pkg                                                       |
// | Purpose  : Shared definitions for the signed divide/remainder front end:    |
// |            RISC-V funct3[1:0] codes, controller state encoding and the      |
// |            pipeline depth of the unsigned divider core.                     |
// | Ports    : none (package)                                                   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

`ifndef LEN_WORD
`define LEN_WORD 32
`endif

package divrem_pkg;

   // funct3[1:0] of the M-extension divide group
   localparam logic [1:0] FN_DIV  = 2'b00;
   localparam logic [1:0] FN_DIVU = 2'b01;
   localparam logic [1:0] FN_REM  = 2'b10;
   localparam logic [1:0] FN_REMU = 2'b11;

   // Stages of the unsigned divu_remu core between accept and done
   localparam int CORE_STAGES = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

`default_nettype wire

// File: rtl/divrem_sign_adj.sv
// +-----------------------------------------------------------------------------+
// | Module   : divrem_sign_adj                                                  |
// | Purpose  : Conditional two's-complement negate, used both to turn signed    |
// |            operands into magnitudes and to restore the sign of a result.    |
// | Ports    : val_i [LEN] value in, neg_i negate request, val_o [LEN] result   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module divrem_sign_adj #(
   parameter int LEN = 32
) (
   input  logic [LEN-1:0] val_i,
   input  logic           neg_i,
   output logic [LEN-1:0] val_o
);

   // Negating the most negative value wraps back to itself, which is exactly
   // the magnitude the unsigned core needs for 0x80..0.
   assign val_o = neg_i ? ({LEN{1'b0}} - val_i) : val_i;

endmodule

`default_nettype wire

// File: rtl/divrem_signed_ctrl.sv
// +-----------------------------------------------------------------------------+
// | Module   : divrem_signed_ctrl                                               |
// | Purpose  : Signed front end for the unsigned multi-cycle divider divu_remu. |
// |            Executes DIV/DIVU/REM/REMU: latches operand magnitudes, issues   |
// |            them to the core, sign-corrects the core result and applies the |
// |            RISC-V divide-by-zero / overflow results.                        |
// | Ports    : clk, rstn (async, active low)                                    |
// |            order/accepted/done, rs1, rs2, funct, rd  - pipeline side        |
// |            core_order/core_accepted/core_done, core_rs1, core_rs2,          |
// |            core_rem_flag, core_rd                    - divider core side    |
// |            timeout_err - sticky flag, core took longer than CORE_TIMEOUT    |
// | Options  : DIVREM_FAST_SPECIAL_EN - resolve divide-by-zero and signed       |
// |            overflow in the accept cycle without ordering the core.          |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
`default_nettype none

module divrem_signed_ctrl
   import divrem_pkg::*;
#(
   parameter int LEN          = 32,
   parameter int CORE_TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           order,
   output logic           accepted,
   output logic           done,
   input  logic [LEN-1:0] rs1,
   input  logic [LEN-1:0] rs2,
   input  logic [1:0]     funct,
   output logic [LEN-1:0] rd,
   output logic           timeout_err,
   output logic           core_order,
   input  logic           core_accepted,
   input  logic           core_done,
   output logic [LEN-1:0] core_rs1,
   output logic [LEN-1:0] core_rs2,
   output logic           core_rem_flag,
   input  logic [LEN-1:0] core_rd
);

   localparam int            CW        = (CORE_TIMEOUT > 0) ? $clog2(CORE_TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LIMIT = CW'(CORE_TIMEOUT);

   generate
      if (LEN != `LEN_WORD) begin : g_len_check
         $error("divrem_signed_ctrl: LEN must equal LEN_WORD");
      end
   endgenerate

   state_e         state_q, state_d;
   logic           negq_q, negq_d;     // quotient needs negation
   logic           negr_q, negr_d;     // remainder needs negation
   logic           zdiv_q, zdiv_d;     // divisor was zero
   logic           rem_q, rem_d;       // REM/REMU selected
   logic [LEN-1:0] crs1_q, crs1_d;
   logic [LEN-1:0] crs2_q, crs2_d;
   logic [LEN-1:0] rd_q, rd_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           err_q, err_d;

   logic           w_signed;
   logic           w_neg1;
   logic           w_neg2;
   logic [LEN-1:0] w_abs1;
   logic [LEN-1:0] w_abs2;
   logic           w_res_neg;
   logic [LEN-1:0] w_res_fix;

   assign w_signed  = ~funct[0];
   assign w_neg1    = w_signed & rs1[LEN-1];
   assign w_neg2    = w_signed & rs2[LEN-1];
   assign w_res_neg = rem_q ? negr_q : negq_q;

   divrem_sign_adj #(.LEN(LEN)) u_adj_rs1 (.val_i(rs1),     .neg_i(w_neg1),    .val_o(w_abs1));
   divrem_sign_adj #(.LEN(LEN)) u_adj_rs2 (.val_i(rs2),     .neg_i(w_neg2),    .val_o(w_abs2));
   divrem_sign_adj #(.LEN(LEN)) u_adj_rd  (.val_i(core_rd), .neg_i(w_res_neg), .val_o(w_res_fix));

`ifdef DIVREM_FAST_SPECIAL_EN
   logic           w_zero;
   logic           w_ovf;
   logic [LEN-1:0] w_fast_rd;

   assign w_zero    = (rs2 == {LEN{1'b0}});
   assign w_ovf     = w_signed & (rs1 == {1'b1, {(LEN-1){1'b0}}}) & (rs2 == {LEN{1'b1}});
   // Zero divisor: Q=all-ones, R=rs1.  Overflow: Q=rs1 (most negative), R=0.
   assign w_fast_rd = funct[1] ? (w_zero ? rs1 : {LEN{1'b0}})
                               : (w_zero ? {LEN{1'b1}} : rs1);
`endif

   always_comb begin
      state_d  = state_q;
      negq_d   = negq_q;
      negr_d   = negr_q;
      zdiv_d   = zdiv_q;
      rem_d    = rem_q;
      crs1_d   = crs1_q;
      crs2_d   = crs2_q;
      rd_d     = rd_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      accepted = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (order) begin
               accepted = 1'b1;
               negq_d   = w_signed & (rs1[LEN-1] ^ rs2[LEN-1]);
               negr_d   = w_neg1;
               zdiv_d   = (rs2 == {LEN{1'b0}});
               rem_d    = funct[1];
               crs1_d   = w_abs1;
               crs2_d   = w_abs2;
`ifdef DIVREM_FAST_SPECIAL_EN
               if (w_zero | w_ovf) begin
                  rd_d    = w_fast_rd;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ISSUE;
               end
`else
               state_d  = ST_ISSUE;
`endif
            end
         end
         ST_ISSUE: begin
            if (core_accepted) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Counter parks at the limit; reaching it means this WAIT cycle is
            // beyond CORE_TIMEOUT.
            if (cnt_q == CNT_LIMIT) begin
               err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
            if (core_done) begin
               // The core already returns R=|rs1| on a zero divisor, so only the
               // quotient needs forcing; the remainder sign fix restores rs1.
               rd_d    = (!rem_q && zdiv_q) ? {LEN{1'b1}} : w_res_fix;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         zdiv_q  <= 1'b0;
         rem_q   <= 1'b0;
         crs1_q  <= '0;
         crs2_q  <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         zdiv_q  <= zdiv_d;
         rem_q   <= rem_d;
         crs1_q  <= crs1_d;
         crs2_q  <= crs2_d;
         rd_q    <= rd_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign done          = (state_q == ST_DONE);
   assign core_order    = (state_q == ST_ISSUE);
   assign rd            = rd_q;
   assign core_rs1      = crs1_q;
   assign core_rs2      = crs2_q;
   assign core_rem_flag = rem_q;
   assign timeout_err   = err_q;

endmodule

`default_nettype wire
